// File: rtl/spi_adc_sequencer.sv
// spi_adc_sequencer: responder for the ADC command/response stream. Each
// command with a channel in range runs one 16-SCLK SPI frame on an external
// 8-channel 12-bit converter. The converter answers with the channel that the
// previous frame addressed, so command tags are held for one frame and come
// back with the next frame's data. The first frame after reset only primes
// that pipeline and produces no response.
module spi_adc_sequencer #(
  parameter int CLK_DIV      = 5,
  parameter int NUM_CHANNELS = 8,
  parameter int DATA_BITS    = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 command_valid,
  input  logic [4:0]           command_channel,
  input  logic                 command_startofpacket,
  input  logic                 command_endofpacket,
  output logic                 command_ready,
  output logic                 response_valid,
  output logic [4:0]           response_channel,
  output logic [DATA_BITS-1:0] response_data,
  output logic                 response_startofpacket,
  output logic                 response_endofpacket,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  output logic                 adc_mosi,
  input  logic                 adc_miso
);

  localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(2 * CLK_DIV);
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, GAP} state_t;

  state_t               state_q;
  logic [DIV_W-1:0]     div_q;
  logic [3:0]           bit_q;
  logic [15:0]          tx_q;
  logic [DATA_BITS-1:0] rx_q;
  logic [4:0]           cur_ch_q, prev_ch_q;
  logic                 cur_sop_q, cur_eop_q, prev_sop_q, prev_eop_q, prev_valid_q;
  logic                 ready_q, cs_n_q, sclk_q, mosi_q;
  logic                 rsp_valid_q, rsp_sop_q, rsp_eop_q;
  logic [4:0]           rsp_ch_q;
  logic [DATA_BITS-1:0] rsp_data_q;

  logic                 accept_d;
  logic                 chan_ok_d;
  logic [15:0]          tx_d;

  // Handshake decode and the control word: two zero bits, the 3-bit address,
  // then don't-care zeros for the rest of the frame.
  always_comb begin
    accept_d  = (state_q == IDLE) && ready_q && command_valid;
    chan_ok_d = (int'(command_channel) < NUM_CHANNELS);
    tx_d      = {2'b00, command_channel[2:0], 11'b0};
  end

  // Frame sequencer: SPI pins, command handshake and response strobe are all
  // registered here. SCLK falls to present a new MOSI bit and MISO is captured
  // on the clk edge that raises SCLK. Only the last DATA_BITS bits are kept,
  // so the converter's leading zeros shift out of rx_q on their own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_q        <= '0;
      bit_q        <= '0;
      ready_q      <= 1'b0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b1;
      mosi_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_ch_q     <= '0;
      rsp_data_q   <= '0;
      rsp_sop_q    <= 1'b0;
      rsp_eop_q    <= 1'b0;
      prev_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          // Out-of-range channels are consumed without touching the pipeline.
          if (accept_d && chan_ok_d) begin
            ready_q   <= 1'b0;
            cur_ch_q  <= command_channel;
            cur_sop_q <= command_startofpacket;
            cur_eop_q <= command_endofpacket;
            tx_q      <= tx_d;
            div_q     <= '0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          cs_n_q <= 1'b0;
          sclk_q <= 1'b1;
          if (div_q == DIV_HALF) begin
            sclk_q  <= 1'b0;
            mosi_q  <= tx_q[15];
            tx_q    <= {tx_q[14:0], 1'b0};
            div_q   <= DIV_ONE;
            bit_q   <= '0;
            state_q <= SHIFT;
          end else begin
            div_q <= div_q + DIV_ONE;
          end
        end
        SHIFT: begin
          if (div_q == DIV_HALF) begin
            sclk_q <= 1'b1;
            rx_q   <= {rx_q[DATA_BITS-2:0], adc_miso};
            div_q  <= div_q + DIV_ONE;
          end else if (div_q == DIV_FULL) begin
            if (bit_q == 4'd15) begin
              cs_n_q <= 1'b1;
              sclk_q <= 1'b1;
              mosi_q <= 1'b0;
              // This frame's data belongs to the previous frame's command.
              if (prev_valid_q) begin
                rsp_valid_q <= 1'b1;
                rsp_ch_q    <= prev_ch_q;
                rsp_data_q  <= rx_q;
                rsp_sop_q   <= prev_sop_q;
                rsp_eop_q   <= prev_eop_q;
              end
              prev_ch_q    <= cur_ch_q;
              prev_sop_q   <= cur_sop_q;
              prev_eop_q   <= cur_eop_q;
              prev_valid_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              sclk_q <= 1'b0;
              mosi_q <= tx_q[15];
              tx_q   <= {tx_q[14:0], 1'b0};
              bit_q  <= bit_q + 4'd1;
              div_q  <= DIV_ONE;
            end
          end else begin
            div_q <= div_q + DIV_ONE;
          end
        end
        DONE: begin
          div_q   <= DIV_ONE;
          state_q <= GAP;
        end
        GAP: begin
          // Keeps chip select high long enough between frames.
          if (div_q == GAP_LAST) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            div_q <= div_q + DIV_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign command_ready          = ready_q;
  assign response_valid         = rsp_valid_q;
  assign response_channel       = rsp_ch_q;
  assign response_data          = rsp_data_q;
  assign response_startofpacket = rsp_sop_q;
  assign response_endofpacket   = rsp_eop_q;
  assign adc_cs_n               = cs_n_q;
  assign adc_sclk               = sclk_q;
  assign adc_mosi               = mosi_q;

endmodule

// File: tb/tb_spi_adc_sequencer.sv
// Directed bench for spi_adc_sequencer: one instance with CLK_DIV=5 and a
// small ADC128S022-like converter model, one with CLK_DIV=2 and MISO high.
module tb_spi_adc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A (CLK_DIV = 5) ----------------
  logic        rst_n, cmd_valid, cmd_sop, cmd_eop;
  logic [4:0]  cmd_ch;
  logic        cmd_ready, rsp_valid, rsp_sop, rsp_eop;
  logic [4:0]  rsp_ch;
  logic [11:0] rsp_data;
  logic        cs_n, sclk, mosi;
  logic        miso = 1'b0;

  spi_adc_sequencer #(.CLK_DIV(5), .NUM_CHANNELS(8), .DATA_BITS(12)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .command_valid(cmd_valid), .command_channel(cmd_ch),
    .command_startofpacket(cmd_sop), .command_endofpacket(cmd_eop),
    .command_ready(cmd_ready),
    .response_valid(rsp_valid), .response_channel(rsp_ch), .response_data(rsp_data),
    .response_startofpacket(rsp_sop), .response_endofpacket(rsp_eop),
    .adc_cs_n(cs_n), .adc_sclk(sclk), .adc_mosi(mosi), .adc_miso(miso)
  );

  // ---------------- instance B (CLK_DIV = 2, MISO stuck high) ----------------
  logic        rst2_n, cmd2_valid;
  logic [4:0]  cmd2_ch;
  logic        cmd2_ready, rsp2_valid, rsp2_sop, rsp2_eop;
  logic [4:0]  rsp2_ch;
  logic [11:0] rsp2_data;
  logic        cs2_n, sclk2, mosi2;

  spi_adc_sequencer #(.CLK_DIV(2), .NUM_CHANNELS(8), .DATA_BITS(12)) u_dut2 (
    .clk(clk), .rst_n(rst2_n),
    .command_valid(cmd2_valid), .command_channel(cmd2_ch),
    .command_startofpacket(1'b0), .command_endofpacket(1'b0),
    .command_ready(cmd2_ready),
    .response_valid(rsp2_valid), .response_channel(rsp2_ch), .response_data(rsp2_data),
    .response_startofpacket(rsp2_sop), .response_endofpacket(rsp2_eop),
    .adc_cs_n(cs2_n), .adc_sclk(sclk2), .adc_mosi(mosi2), .adc_miso(1'b1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Converter model for instance A: conversion value per channel, returned in
  // the frame after the one that addressed it (16 bits, 4 leading zeros).
  logic [11:0] conv [8] = '{12'h123, 12'h456, 12'h789, 12'hABC,
                            12'hDEF, 12'h5A5, 12'h3C3, 12'h0F0};
  logic [2:0]  adc_addr = 3'd0;
  logic [15:0] adc_word = 16'h0;
  int          bidx = 0;
  logic        cs_prev = 1'b1, sclk_prev = 1'b1;
  logic [15:0] mosi_sh = 16'h0, frame_mosi = 16'h0;
  int          rises = 0, frame_rises = 0, frames = 0;
  int          cs_fall_cyc = 0, cs_last_cyc = 0;
  int          rsp_cnt = 0, rsp_cyc = 0, rsp_cyc_prev = 0;
  logic [4:0]  cap_ch = 5'd0;
  logic [11:0] cap_data = 12'h0;
  logic        cap_sop = 1'b0, cap_eop = 1'b0;

  always @(negedge clk) begin
    if (cs_n === 1'b0 && cs_prev === 1'b1) begin
      cs_fall_cyc = cyc;
      mosi_sh     = 16'h0;
      rises       = 0;
      bidx        = 0;
      adc_word    = {4'h0, conv[adc_addr]};
    end
    if (cs_n === 1'b1 && cs_prev === 1'b0) begin
      frame_mosi  = mosi_sh;
      frame_rises = rises;
      frames++;
      if (rises == 16) adc_addr = mosi_sh[13:11];
    end
    if (cs_n === 1'b0) cs_last_cyc = cyc;
    if (cs_n === 1'b0 && sclk === 1'b1 && sclk_prev === 1'b0) begin
      mosi_sh = {mosi_sh[14:0], mosi};
      rises++;
    end
    if (cs_n === 1'b0 && sclk === 1'b0 && sclk_prev === 1'b1 && bidx < 16) begin
      miso = adc_word[4'(15 - bidx)];
      bidx++;
    end
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      rsp_cyc_prev = rsp_cyc;
      rsp_cyc  = cyc;
      cap_ch   = rsp_ch;
      cap_data = rsp_data;
      cap_sop  = rsp_sop;
      cap_eop  = rsp_eop;
    end
    cs_prev   = cs_n;
    sclk_prev = sclk;
  end

  // Monitor for instance B.
  logic        cs2_prev = 1'b1, sclk2_prev = 1'b1;
  int          rises2 = 0, frame_rises2 = 0, r0_cyc = 0, r1_cyc = 0;
  int          rsp2_cnt = 0, rsp2_cyc = 0;
  logic [4:0]  cap2_ch = 5'd0;
  logic [11:0] cap2_data = 12'h0;

  always @(negedge clk) begin
    if (cs2_n === 1'b0 && cs2_prev === 1'b1) rises2 = 0;
    if (cs2_n === 1'b0 && sclk2 === 1'b1 && sclk2_prev === 1'b0) begin
      if (rises2 == 0) r0_cyc = cyc;
      if (rises2 == 1) r1_cyc = cyc;
      rises2++;
    end
    if (cs2_n === 1'b1 && cs2_prev === 1'b0) frame_rises2 = rises2;
    if (rsp2_valid === 1'b1) begin
      rsp2_cnt++;
      rsp2_cyc  = cyc;
      cap2_ch   = rsp2_ch;
      cap2_data = rsp2_data;
    end
    cs2_prev   = cs2_n;
    sclk2_prev = sclk2;
  end

  task automatic wait_ready();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) return;
    end
    check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Issue one command on instance A; t is the accepting clock edge.
  task automatic send(input logic [4:0] ch, input logic sop, input logic eop, output int t);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_sop   = sop;
    cmd_eop   = eop;
    @(posedge clk);
    #1 t = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (rsp_cnt >= n) return;
    end
    check("rsp_timeout", 32'(rsp_cnt), 32'(n));
  endtask

  task automatic send2(input logic [4:0] ch, output int t);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd2_ready === 1'b1) break;
    end
    cmd2_valid = 1'b1;
    cmd2_ch    = ch;
    @(posedge clk);
    #1 t = cyc;
    cmd2_valid = 1'b0;
  endtask

  int t, t0, base, fr;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_ch = 5'd0; cmd_sop = 1'b0; cmd_eop = 1'b0;
    rst2_n = 1'b0; cmd2_valid = 1'b0; cmd2_ch = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd1);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_fields", {13'd0, rsp_ch, rsp_data, rsp_sop, rsp_eop}, 32'd0);
    rst_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Dummy first frame: ch3.
    send(5'd3, 1'b1, 1'b0, t);
    wait_ready();
    check("f1_ready_cyc", 32'(cyc - t), 32'd171);
    check("f1_cs_fall", 32'(cs_fall_cyc - t), 32'd1);
    check("f1_cs_last", 32'(cs_last_cyc - t), 32'd165);
    check("f1_mosi", 32'(frame_mosi), 32'h1800);
    check("f1_rises", 32'(frame_rises), 32'd16);
    check("f1_no_rsp", 32'(rsp_cnt), 32'd0);

    // Second frame ch5 returns ch3 data.
    send(5'd5, 1'b0, 1'b1, t);
    wait_ready();
    check("f2_rsp_cnt", 32'(rsp_cnt), 32'd1);
    check("f2_rsp_cyc", 32'(rsp_cyc - t), 32'd166);
    check("f2_rsp_ch", 32'(cap_ch), 32'd3);
    check("f2_rsp_data", 32'(cap_data), 32'hABC);
    check("f2_rsp_sop_eop", {30'd0, cap_sop, cap_eop}, 32'b10);
    check("f2_mosi", 32'(frame_mosi), 32'h2800);
    check("f2_hold_ch", 32'(rsp_ch), 32'd3);
    check("f2_valid_low", 32'(rsp_valid), 32'd0);

    // Out-of-range channel is swallowed.
    fr = frames;
    send(5'd9, 1'b1, 1'b1, t);
    @(negedge clk);
    check("ch9_ready", 32'(cmd_ready), 32'd1);
    repeat (20) @(negedge clk);
    check("ch9_no_frame", 32'(frames), 32'(fr));
    check("ch9_cs_idle", 32'(cs_n), 32'd1);
    send(5'd2, 1'b1, 1'b1, t);
    wait_ready();
    check("f3_rsp_cnt", 32'(rsp_cnt), 32'd2);
    check("f3_rsp_ch", 32'(cap_ch), 32'd5);
    check("f3_rsp_data", 32'(cap_data), 32'h5A5);
    check("f3_rsp_sop_eop", {30'd0, cap_sop, cap_eop}, 32'b01);
    check("f3_mosi", 32'(frame_mosi), 32'h1000);

    // Reset in the middle of bit 7.
    send(5'd1, 1'b0, 1'b0, t);
    t0 = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cs_n === 1'b0 && sclk === 1'b0 && rises == 7) begin t0 = 1; break; end
    end
    check("midrst_reached", 32'(t0), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_cs_n", 32'(cs_n), 32'd1);
    check("midrst_sclk", 32'(sclk), 32'd1);
    check("midrst_ready", 32'(cmd_ready), 32'd0);
    check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_back", 32'(cmd_ready), 32'd1);
    send(5'd4, 1'b1, 1'b0, t);
    wait_ready();
    check("postrst_dummy", 32'(rsp_cnt), 32'd2);
    send(5'd6, 1'b0, 1'b0, t);
    wait_ready();
    check("postrst_rsp_cnt", 32'(rsp_cnt), 32'd3);
    check("postrst_rsp_ch", 32'(cap_ch), 32'd4);
    check("postrst_rsp_data", 32'(cap_data), 32'hDEF);
    check("postrst_sop_eop", {30'd0, cap_sop, cap_eop}, 32'b10);

    // Command held valid: one frame every 172 cycles.
    base = rsp_cnt;
    cmd_valid = 1'b1; cmd_ch = 5'd7; cmd_sop = 1'b0; cmd_eop = 1'b0;
    wait_rsp(base + 1);
    check("stream_r1_ch", 32'(cap_ch), 32'd6);
    check("stream_r1_data", 32'(cap_data), 32'h3C3);
    wait_rsp(base + 2);
    wait_rsp(base + 3);
    check("stream_r3_ch", 32'(cap_ch), 32'd7);
    check("stream_r3_data", 32'(cap_data), 32'h0F0);
    check("stream_period", 32'(rsp_cyc - rsp_cyc_prev), 32'd172);
    cmd_valid = 1'b0;

    // Instance B: CLK_DIV=2 timing and all-ones data.
    send2(5'd0, t);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd2_ready === 1'b1) break;
    end
    check("b_rises", 32'(frame_rises2), 32'd16);
    check("b_sclk_period", 32'(r1_cyc - r0_cyc), 32'd4);
    check("b_dummy", 32'(rsp2_cnt), 32'd0);
    send2(5'd0, t);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd2_ready === 1'b1) break;
    end
    check("b_rsp_cnt", 32'(rsp2_cnt), 32'd1);
    check("b_rsp_cyc", 32'(rsp2_cyc - t), 32'd67);
    check("b_rsp_data", 32'(cap2_data), 32'hFFF);
    check("b_rsp_ch", 32'(cap2_ch), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
